rob_writeback: RTL and testbench

- Reorder buffer that is the single writer of the register file's rename-aware write channel (write_en/addr/restore/is_ref/data).
- Allocates entries in program order and writes the rename tag (ROB id) into the destination register.
- Takes completion results from execution, commits in order, and writes architectural values back.
- On flush, walks the register file and issues restore writes to drop every outstanding rename tag.

---
 rtl/rob_writeback_pkg.sv | 32 +++
 rtl/rob_writeback_rename_shadow.sv | 37 +++
 rtl/rob_writeback.sv | 188 ++++++++++++++++++
 tb/tb_rob_writeback.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_writeback_pkg.sv
// Shared widths and FSM encoding for the reorder buffer writeback slice.
// The register file imports the same constants.
package rob_writeback_pkg;

  localparam int ROB_ADDR_WIDTH = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ROB_DEPTH      = 2 ** ROB_ADDR_WIDTH;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_REREF = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_id_t;
  typedef logic [ROB_ADDR_WIDTH:0]   rob_cnt_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    logic      restore;
    logic      is_ref;
    data_t     data;
  } rf_wr_t;

  function automatic data_t id_to_data(rob_id_t id);
    return {{(DATA_WIDTH-ROB_ADDR_WIDTH){1'b0}}, id};
  endfunction

endpackage

// File: rtl/rob_writeback_rename_shadow.sv
// Newest rename tag per architectural register, with one
// set port, one clear port and one lookup port.
module rob_rename_shadow
  import rob_writeback_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
  input  logic [ROB_ADDR_WIDTH-1:0] set_id_i,
  input  logic                      clr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] q_addr_i,
  output logic                      q_valid_o,
  output logic [ROB_ADDR_WIDTH-1:0] q_id_o
);

  logic [NUM_REGS-1:0] ren_valid_q;
  rob_id_t             ren_id_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ren_valid_q <= '0;
    end else begin
      if (clr_en_i) ren_valid_q[clr_addr_i] <= 1'b0;
      if (set_en_i) ren_valid_q[set_addr_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en_i) ren_id_q[set_addr_i] <= set_id_i;
  end

  assign q_valid_o = ren_valid_q[q_addr_i];
  assign q_id_o    = ren_id_q[q_addr_i];

endmodule

// File: rtl/rob_writeback.sv
// Reorder buffer: in-order allocate/commit, sole driver of the
// register file's rename-aware write port, flush restore walk.
module rob_writeback
  import rob_writeback_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_dest,
  output logic                      alloc_ready,
  output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
  input  logic                      wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      flush,
  output logic                      flush_busy,
  output logic                      commit_valid,
  output logic [ROB_ADDR_WIDTH-1:0] commit_id,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic                      rf_write_restore,
  output logic                      rf_write_is_ref,
  output logic [DATA_WIDTH-1:0]     rf_write_data
);

  logic [1:0] state_q, state_d;
  rob_id_t    head_q, head_d;
  rob_id_t    tail_q, tail_d;
  rob_cnt_t   count_q, count_d;
  reg_addr_t  idx_q, idx_d;
  reg_addr_t  reref_q, reref_d;

  logic [ROB_DEPTH-1:0] valid_q, done_q;
  reg_addr_t            dest_q  [ROB_DEPTH];
  data_t                value_q [ROB_DEPTH];

  logic      run_s, reref_s, flush_s;
  logic      commit, commit_wr, commit_clr, commit_reref;
  logic      alloc_fire, alloc_ref, wb_fire, flush_take;
  logic      walk_wr, reref_wr;
  reg_addr_t head_dest, q_addr, clr_addr;
  logic      q_valid;
  rob_id_t   q_id;
  rf_wr_t    wr;

  assign run_s   = rst && (state_q == ST_RUN);
  assign reref_s = rst && (state_q == ST_REREF);
  assign flush_s = rst && (state_q == ST_FLUSH);

  assign head_dest = dest_q[head_q];
  assign q_addr    = flush_s ? idx_q : (reref_s ? reref_q : head_dest);
  assign clr_addr  = flush_s ? idx_q : head_dest;

  // Commit reads registered done; flush beats a ready head.
  assign commit       = run_s && valid_q[head_q] && done_q[head_q]
                        && !flush;
  assign commit_wr    = commit && (head_dest != '0);
  assign commit_clr   = commit_wr && q_valid && (q_id == head_q);
  assign commit_reref = commit_wr && q_valid && (q_id != head_q);

  assign alloc_ready = run_s && (count_q < rob_cnt_t'(ROB_DEPTH))
                       && !flush && !commit_wr;
  assign alloc_fire  = alloc_en && alloc_ready;
  assign alloc_ref   = alloc_fire && (alloc_dest != '0);
  assign wb_fire     = (run_s || reref_s) && wb_en && valid_q[wb_id];
  assign flush_take  = flush && (run_s || reref_s);
  assign walk_wr     = flush_s && q_valid;
  assign reref_wr    = reref_s && !flush;

  rob_rename_shadow u_shadow (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (alloc_ref),
    .set_addr_i (alloc_dest),
    .set_id_i   (tail_q),
    .clr_en_i   (walk_wr || commit_clr),
    .clr_addr_i (clr_addr),
    .q_addr_i   (q_addr),
    .q_valid_o  (q_valid),
    .q_id_o     (q_id)
  );

  always_comb begin
    wr = '0;
    unique case (1'b1)
      walk_wr: begin
        wr.en      = 1'b1;
        wr.addr    = idx_q;
        wr.restore = 1'b1;
      end
      reref_wr: begin
        wr.en     = 1'b1;
        wr.addr   = reref_q;
        wr.is_ref = 1'b1;
        wr.data   = id_to_data(q_id);
      end
      commit_wr: begin
        wr.en   = 1'b1;
        wr.addr = head_dest;
        wr.data = value_q[head_q];
      end
      alloc_ref: begin
        wr.en     = 1'b1;
        wr.addr   = alloc_dest;
        wr.is_ref = 1'b1;
        wr.data   = id_to_data(tail_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    reref_d = reref_q;
    head_d  = commit ? head_q + rob_id_t'(1) : head_q;
    tail_d  = alloc_fire ? tail_q + rob_id_t'(1) : tail_q;
    count_d = count_q;
    if (alloc_fire && !commit) count_d = count_q + rob_cnt_t'(1);
    else if (commit && !alloc_fire) count_d = count_q - rob_cnt_t'(1);
    if (flush_take) begin
      state_d = ST_FLUSH;
      idx_d   = reg_addr_t'(1);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (reref_s) begin
      state_d = ST_RUN;
    end else if (flush_s) begin
      idx_d = idx_q + reg_addr_t'(1);
      if (&idx_q) state_d = ST_RUN;
    end else if (commit_reref) begin
      state_d = ST_REREF;
      reref_d = head_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      reref_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      reref_q <= reref_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_take) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb_fire) done_q[wb_id] <= 1'b1;
      if (commit) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_fire) value_q[wb_id] <= wb_data;
    if (alloc_fire) dest_q[tail_q] <= alloc_dest;
  end

  assign alloc_id         = rst ? tail_q : '0;
  assign flush_busy       = flush_s;
  assign commit_valid     = commit;
  assign commit_id        = commit ? head_q : '0;
  assign rf_write_en      = wr.en;
  assign rf_write_addr    = wr.addr;
  assign rf_write_restore = wr.restore;
  assign rf_write_is_ref  = wr.is_ref;
  assign rf_write_data    = wr.data;

endmodule

// File: tb/tb_rob_writeback.sv
// Random + directed stimulus against a queue-based ROB model;
// expected events are queued and matched by a separate monitor.
module tb_rob_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_dest = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_id;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_id = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic        rf_write_restore;
  logic        rf_write_is_ref;
  logic [31:0] rf_write_data;

  rob_writeback dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_en         (alloc_en),
    .alloc_dest       (alloc_dest),
    .alloc_ready      (alloc_ready),
    .alloc_id         (alloc_id),
    .wb_en            (wb_en),
    .wb_id            (wb_id),
    .wb_data          (wb_data),
    .flush            (flush),
    .flush_busy       (flush_busy),
    .commit_valid     (commit_valid),
    .commit_id        (commit_id),
    .rf_write_en      (rf_write_en),
    .rf_write_addr    (rf_write_addr),
    .rf_write_restore (rf_write_restore),
    .rf_write_is_ref  (rf_write_is_ref),
    .rf_write_data    (rf_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          dest;
    bit          done;
    logic [31:0] val;
  } ent_t;
  typedef struct {
    int          cyc;
    int          addr;
    bit          rest;
    bit          isref;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    int cyc;
    int id;
  } cm_t;
  typedef struct {
    int cyc;
    bit ar;
    int aid;
    bit busy;
  } st_t;

  ent_t rob[$];
  bit   ren_v [32];
  int   ren_id [32];
  int   mst, mreg, midx, mtail;
  wr_t  wq[$];
  cm_t  cq[$];
  st_t  sq[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit fin = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input bit r, input bit ir,
                         input logic [31:0] d);
    wr_t w;
    w.cyc = cyc; w.addr = a; w.rest = r; w.isref = ir; w.data = d;
    wq.push_back(w);
  endtask

  task automatic apply_wb(input bit we, input int wi,
                          input logic [31:0] wd);
    if (we)
      foreach (rob[i])
        if (rob[i].id == wi) begin
          rob[i].done = 1'b1;
          rob[i].val  = wd;
        end
  endtask

  task automatic start_flush();
    rob.delete();
    mtail = 0;
    mst   = 2;
    midx  = 1;
  endtask

  // Reference behaviour for one clock cycle with the given inputs.
  task automatic model(input bit ae, input int ad, input bit we,
                       input int wi, input logic [31:0] wd,
                       input bit fl, input bit rs);
    st_t s;
    cm_t c;
    bit  com, cw, ar;
    int  d;
    s.cyc  = cyc;
    s.busy = rs && (mst == 2);
    s.aid  = rs ? mtail : 0;
    s.ar   = 1'b0;
    if (!rs) begin
      sq.push_back(s);
      rob.delete();
      mtail = 0; mst = 0; midx = 0;
      foreach (ren_v[i]) ren_v[i] = 1'b0;
      return;
    end
    if (mst == 2) begin
      sq.push_back(s);
      if (ren_v[midx]) begin
        push_wr(midx, 1'b1, 1'b0, 32'h0);
        ren_v[midx] = 1'b0;
      end
      if (midx == 31) mst = 0;
      midx++;
      return;
    end
    if (mst == 1) begin
      sq.push_back(s);
      if (!fl) push_wr(mreg, 1'b0, 1'b1, 32'(ren_id[mreg]));
      apply_wb(we, wi, wd);
      mst = 0;
      if (fl) start_flush();
      return;
    end
    com = !fl && rob.size() > 0 && rob[0].done;
    cw  = com && rob[0].dest != 0;
    ar  = !fl && rob.size() < 16 && !cw;
    s.ar = ar;
    sq.push_back(s);
    if (com) begin
      c.cyc = cyc; c.id = rob[0].id;
      cq.push_back(c);
      d = rob[0].dest;
      if (cw) begin
        push_wr(d, 1'b0, 1'b0, rob[0].val);
        if (ren_v[d] && ren_id[d] == rob[0].id) ren_v[d] = 1'b0;
        else if (ren_v[d]) begin mst = 1; mreg = d; end
      end
      void'(rob.pop_front());
    end
    apply_wb(we, wi, wd);
    if (ae && ar) begin
      ent_t e;
      e.id = mtail; e.dest = ad; e.done = 1'b0; e.val = '0;
      rob.push_back(e);
      if (ad != 0) begin
        push_wr(ad, 1'b0, 1'b1, 32'(mtail));
        ren_v[ad] = 1'b1;
        ren_id[ad] = mtail;
      end
      mtail = (mtail + 1) % 16;
    end
    if (fl) start_flush();
  endtask

  task automatic step(input bit ae, input int ad, input bit we,
                      input int wi, input logic [31:0] wd,
                      input bit fl, input bit rs);
    @(negedge clk);
    cyc++;
    alloc_en = ae; alloc_dest = 5'(ad);
    wb_en = we; wb_id = 4'(wi); wb_data = wd;
    flush = fl; rst = rs;
    model(ae, ad, we, wi, wd, fl, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, '0, 0, 0);
    idle(1);
  endtask

  initial begin : monitor
    st_t s;
    cm_t c;
    wr_t w;
    while (!fin) begin
      @(negedge clk);
      #2;
      if (fin) break;
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        chk("alloc_ready", alloc_ready, s.ar);
        chk("alloc_id", alloc_id, s.aid);
        chk("flush_busy", flush_busy, s.busy);
      end
      if (commit_valid) begin
        if (cq.size() == 0) chk("commit_extra", commit_valid, 0);
        else begin
          c = cq.pop_front();
          chk("commit_cyc", cyc, c.cyc);
          chk("commit_id", commit_id, c.id);
        end
      end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
        c = cq.pop_front();
        chk("commit_missing", commit_valid, 1);
      end
      if (rf_write_en) begin
        if (wq.size() == 0) chk("rf_extra", rf_write_en, 0);
        else begin
          w = wq.pop_front();
          chk("rf_cyc", cyc, w.cyc);
          chk("rf_addr", rf_write_addr, w.addr);
          chk("rf_restore", rf_write_restore, w.rest);
          chk("rf_is_ref", rf_write_is_ref, w.isref);
          chk("rf_data", rf_write_data, w.data);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        w = wq.pop_front();
        chk("rf_missing", rf_write_en, 1);
      end
    end
  end

  initial begin : driver
    int wi;
    do_reset();
    // single alloc/complete/commit
    step(1, 3, 0, 0, '0, 0, 1);
    step(0, 0, 1, 0, 32'hAB, 0, 1);
    idle(3);
    // superseded rename -> REREF
    do_reset();
    step(1, 5, 0, 0, '0, 0, 1);
    step(1, 5, 0, 0, '0, 0, 1);
    step(0, 0, 1, 0, 32'h11, 0, 1);
    idle(4);
    // fill, refuse, free one, wrap tail
    do_reset();
    for (int i = 0; i < 16; i++) step(1, i + 1, 0, 0, '0, 0, 1);
    step(1, 9, 0, 0, '0, 0, 1);
    step(0, 0, 1, 0, 32'h55, 0, 1);
    step(1, 20, 0, 0, '0, 0, 1);
    step(1, 21, 0, 0, '0, 0, 1);
    // flush restore walk
    do_reset();
    step(1, 2, 0, 0, '0, 0, 1);
    step(1, 7, 0, 0, '0, 0, 1);
    step(1, 0, 0, 0, '0, 0, 1);
    step(0, 0, 0, 0, '0, 1, 1);
    idle(34);
    step(1, 4, 0, 0, '0, 0, 1);
    // dest-0 commit shares cycle with alloc
    do_reset();
    step(1, 0, 0, 0, '0, 0, 1);
    step(0, 0, 1, 0, 32'h77, 0, 1);
    step(1, 9, 0, 0, '0, 0, 1);
    idle(2);
    // reset while in REREF
    do_reset();
    step(1, 5, 0, 0, '0, 0, 1);
    step(1, 5, 0, 0, '0, 0, 1);
    step(0, 0, 1, 0, 32'h11, 0, 1);
    step(0, 0, 0, 0, '0, 0, 1);
    step(0, 0, 0, 0, '0, 0, 0);
    idle(3);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (rob.size() > 0 && $urandom_range(0, 3) != 0)
        wi = rob[$urandom_range(0, rob.size() - 1)].id;
      else
        wi = $urandom_range(0, 15);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, wi, $urandom,
           $urandom_range(0, 99) < 2, $urandom_range(0, 299) != 0);
    end
    idle(40);
    @(negedge clk);
    #3;
    fin = 1'b1;
    chk("leftover_rf", wq.size(), 0);
    chk("leftover_commit", cq.size(), 0);
    chk("leftover_status", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
